// File: rtl/sc_gameprogress_controller_pkg.sv
// Shared definitions for the Frogger game-progress controller: state encoding,
// parameter defaults and the level-to-tick-period mapping.
package sc_game_pkg;

  localparam logic [1:0] ST_IDLE_C  = 2'd0;
  localparam logic [1:0] ST_RUN_C   = 2'd1;
  localparam logic [1:0] ST_PAUSE_C = 2'd2;
  localparam logic [1:0] ST_OVER_C  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_C,
    ST_RUN   = ST_RUN_C,
    ST_PAUSE = ST_PAUSE_C,
    ST_OVER  = ST_OVER_C
  } state_e;

  localparam int LIVES_INIT_DEF   = 3;
  localparam int LEVEL_MAX_DEF    = 4;
  localparam int PAUSE_CYCLES_DEF = 25_000_000;
  localparam int TICK_BASE_DEF    = 12_500_000;
  localparam int TICK_STEP_DEF    = 2_500_000;

  // Obstacles speed up linearly with level; TICK_BASE must exceed LEVEL_MAX*TICK_STEP.
  function automatic int tick_period(input int base, input int step, input int level);
    return base - level * step;
  endfunction

endpackage

// File: rtl/sc_gameprogress_controller_if.sv
// Command/status bundle between the game state machine (master) and the
// progress controller (slave). All command pulses are active low.
interface sc_gameprogress_if
  import sc_game_pkg::*;
#(
  parameter int LIVES_INIT = LIVES_INIT_DEF,
  parameter int LEVEL_MAX  = LEVEL_MAX_DEF
);
  localparam int LIVES_W = $clog2(LIVES_INIT + 1);
  localparam int LEVEL_W = $clog2(LEVEL_MAX + 1);

  logic               start_InLow;
  logic               loseLife_InLow;
  logic               nextLevel_InLow;
  logic [LIVES_W-1:0] lives_Out;
  logic [LEVEL_W-1:0] level_Out;
  logic               livesComparator_OutLow;
  logic               levelComparator_OutLow;
  logic               freeze_OutLow;
  logic               tick_OutLow;

  modport master (
    output start_InLow, loseLife_InLow, nextLevel_InLow,
    input  lives_Out, level_Out, livesComparator_OutLow, levelComparator_OutLow,
           freeze_OutLow, tick_OutLow
  );

  modport slave (
    input  start_InLow, loseLife_InLow, nextLevel_InLow,
    output lives_Out, level_Out, livesComparator_OutLow, levelComparator_OutLow,
           freeze_OutLow, tick_OutLow
  );

endinterface

// File: rtl/sc_gameprogress_controller_tick.sv
// Loadable modulo-P counter: counts 0..period-1 while enabled and emits a
// registered one-cycle pulse on terminal count, then wraps.
module sc_tick_divider #(
  parameter int W = 24
) (
  input  logic         SC_STATEMACHINEGAME_CLOCK_50,
  input  logic         SC_STATEMACHINEGAME_RESET_InHigh,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] period,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;
  logic         term_cnt;

  // >= rather than == so a shortened period cannot strand the counter above it.
  assign term_cnt = (cnt_q >= (period - 1'b1));

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (term_cnt) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/sc_gameprogress_controller.sv
// Lives/level bookkeeping, post-event freeze timer and obstacle tick sequencer.
//   state | meaning
//   IDLE  | after reset, waiting for start; frozen, no ticks
//   RUN   | game active; ticks issued, events accepted
//   PAUSE | freeze interval after lose-life / next-level
//   OVER  | lives exhausted or last level reached; only start leaves
module sc_gameprogress_controller
  import sc_game_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int LEVEL_MAX    = LEVEL_MAX_DEF,
  parameter int PAUSE_CYCLES = PAUSE_CYCLES_DEF,
  parameter int TICK_BASE    = TICK_BASE_DEF,
  parameter int TICK_STEP    = TICK_STEP_DEF
) (
  input logic              SC_STATEMACHINEGAME_CLOCK_50,
  input logic              SC_STATEMACHINEGAME_RESET_InHigh,
  sc_gameprogress_if.slave bus
);

  localparam int LIVES_W = $clog2(LIVES_INIT + 1);
  localparam int LEVEL_W = $clog2(LEVEL_MAX + 1);
  localparam int PER_W   = $clog2(TICK_BASE + 1);
  localparam int PAUSE_W = $clog2(PAUSE_CYCLES + 1);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic               freeze_n_q, freeze_n_d;
  logic               lives_n_q, lives_n_d;
  logic               level_n_q, level_n_d;

  logic start, lose_life, next_level;
  logic tick_clear, tick_en, tick;

  assign start      = ~bus.start_InLow;
  assign lose_life  = ~bus.loseLife_InLow;
  assign next_level = ~bus.nextLevel_InLow;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    pause_d = pause_q;
    if (start) begin
      lives_d = LIVES_W'(LIVES_INIT);
      level_d = '0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lose_life) begin
            lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
            state_d = (lives_d == '0) ? ST_OVER : ST_PAUSE;
            pause_d = PAUSE_W'(PAUSE_CYCLES - 1);
          end else if (next_level) begin
            level_d = (level_q == LEVEL_W'(LEVEL_MAX)) ? level_q : level_q + 1'b1;
            state_d = (level_d == LEVEL_W'(LEVEL_MAX)) ? ST_OVER : ST_PAUSE;
            pause_d = PAUSE_W'(PAUSE_CYCLES - 1);
          end
        end
        ST_PAUSE: begin
          if (pause_q == '0) state_d = ST_RUN;
          else               pause_d = pause_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Flags and freeze follow the next state so they change on the event edge itself.
  assign freeze_n_d = (state_d == ST_RUN);
  assign lives_n_d  = (lives_d != '0);
  assign level_n_d  = (level_d != LEVEL_W'(LEVEL_MAX));
  assign period_d   = PER_W'(tick_period(TICK_BASE, TICK_STEP, int'(level_q)));

  assign tick_clear = (state_d == ST_RUN) && ((state_q != ST_RUN) || start);
  assign tick_en    = (state_q == ST_RUN) && (state_d == ST_RUN) && !start;

  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      state_q    <= ST_IDLE;
      lives_q    <= LIVES_W'(LIVES_INIT);
      level_q    <= '0;
      pause_q    <= '0;
      period_q   <= PER_W'(TICK_BASE);
      freeze_n_q <= 1'b0;
      lives_n_q  <= 1'b1;
      level_n_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      pause_q    <= pause_d;
      period_q   <= period_d;
      freeze_n_q <= freeze_n_d;
      lives_n_q  <= lives_n_d;
      level_n_q  <= level_n_d;
    end
  end

  sc_tick_divider #(
    .W (PER_W)
  ) u_tick (
    .SC_STATEMACHINEGAME_CLOCK_50     (SC_STATEMACHINEGAME_CLOCK_50),
    .SC_STATEMACHINEGAME_RESET_InHigh (SC_STATEMACHINEGAME_RESET_InHigh),
    .clear                            (tick_clear),
    .enable                           (tick_en),
    .period                           (period_q),
    .tick_o                           (tick)
  );

  assign bus.lives_Out              = lives_q;
  assign bus.level_Out              = level_q;
  assign bus.livesComparator_OutLow = lives_n_q;
  assign bus.levelComparator_OutLow = level_n_q;
  assign bus.freeze_OutLow          = freeze_n_q;
  assign bus.tick_OutLow            = ~tick;

endmodule

// File: tb/tb_sc_gameprogress_controller.sv
// Scoreboard bench: a behavioural game model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the controller.
module tb_sc_gameprogress_controller;

  localparam int LI = 3;
  localparam int LM = 4;
  localparam int PC = 4;
  localparam int TB = 10;
  localparam int TS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_gameprogress_if #(.LIVES_INIT(LI), .LEVEL_MAX(LM)) bus ();

  sc_gameprogress_controller #(
    .LIVES_INIT   (LI),
    .LEVEL_MAX    (LM),
    .PAUSE_CYCLES (PC),
    .TICK_BASE    (TB),
    .TICK_STEP    (TS)
  ) dut (
    .SC_STATEMACHINEGAME_CLOCK_50     (clk),
    .SC_STATEMACHINEGAME_RESET_InHigh (rst),
    .bus                              (bus)
  );

  typedef struct {
    int lives;
    int level;
    bit running;
    bit tick;
  } exp_t;

  exp_t  sb_q[$];
  int    errors = 0;
  int    checks = 0;

  string m_mode;
  int    m_lives, m_level, m_pause_left, m_age;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = "IDLE";
    m_lives = LI;
    m_level = 0;
    m_pause_left = 0;
    m_age = 0;
  endtask

  task automatic model_step(input bit s, input bit l, input bit n, output bit tk);
    tk = 1'b0;
    if (rst) begin
      model_reset();
    end else if (s) begin
      m_lives = LI;
      m_level = 0;
      m_mode = "RUN";
      m_age = 0;
    end else if (m_mode == "RUN") begin
      if (l) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_mode = (m_lives == 0) ? "OVER" : "PAUSE";
        m_pause_left = PC;
      end else if (n) begin
        m_level = (m_level < LM) ? m_level + 1 : LM;
        m_mode = (m_level == LM) ? "OVER" : "PAUSE";
        m_pause_left = PC;
      end else begin
        m_age++;
        if (m_age % (TB - m_level * TS) == 0) tk = 1'b1;
      end
    end else if (m_mode == "PAUSE") begin
      m_pause_left--;
      if (m_pause_left == 0) begin
        m_mode = "RUN";
        m_age = 0;
      end
    end
  endtask

  task automatic cycle(input bit s, input bit l, input bit n);
    exp_t e;
    bit   tk;
    bus.start_InLow     = ~s;
    bus.loseLife_InLow  = ~l;
    bus.nextLevel_InLow = ~n;
    @(posedge clk);
    #1;
    model_step(s, l, n, tk);
    e.lives   = m_lives;
    e.level   = m_level;
    e.running = (m_mode == "RUN");
    e.tick    = tk;
    sb_q.push_back(e);
    bus.start_InLow     = 1'b1;
    bus.loseLife_InLow  = 1'b1;
    bus.nextLevel_InLow = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges: outputs must clear without waiting for a clock.
  task automatic reset_now();
    #1;
    rst = 1'b1;
    #1;
    sb_q.delete();
    chk("rst_lives", int'(bus.lives_Out), LI);
    chk("rst_level", int'(bus.level_Out), 0);
    chk("rst_lives_flag", int'(bus.livesComparator_OutLow), 1);
    chk("rst_level_flag", int'(bus.levelComparator_OutLow), 1);
    chk("rst_freeze", int'(bus.freeze_OutLow), 0);
    chk("rst_tick", int'(bus.tick_OutLow), 1);
    model_reset();
    idle(3);
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("lives", int'(bus.lives_Out), e.lives);
        chk("level", int'(bus.level_Out), e.level);
        chk("lives_flag", int'(bus.livesComparator_OutLow), (e.lives != 0) ? 1 : 0);
        chk("level_flag", int'(bus.levelComparator_OutLow), (e.level != LM) ? 1 : 0);
        chk("freeze", int'(bus.freeze_OutLow), e.running ? 1 : 0);
        chk("tick", int'(bus.tick_OutLow), e.tick ? 0 : 1);
      end
    end
  end

  initial begin
    int r;
    bus.start_InLow     = 1'b1;
    bus.loseLife_InLow  = 1'b1;
    bus.nextLevel_InLow = 1'b1;
    model_reset();
    idle(3);
    rst = 1'b0;

    // Idle: events ignored, frozen, no ticks.
    idle(20);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    idle(28);

    // Start then run: ticks at 10, 20, 30.
    cycle(1'b1, 1'b0, 1'b0);
    idle(35);

    // Single lose-life, pause, resume.
    cycle(1'b0, 1'b1, 1'b0);
    idle(20);

    // Drain remaining lives to OVER, poke it, restart.
    cycle(1'b0, 1'b1, 1'b0);
    idle(7);
    cycle(1'b0, 1'b1, 1'b0);
    idle(5);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b1);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0);
    idle(15);

    // Levels: period 6 at level 2, OVER at level 4.
    cycle(1'b0, 1'b0, 1'b1);
    idle(6);
    cycle(1'b0, 1'b0, 1'b1);
    idle(25);
    cycle(1'b0, 1'b0, 1'b1);
    idle(10);
    cycle(1'b0, 1'b0, 1'b1);
    idle(5);
    cycle(1'b0, 1'b1, 1'b0);

    // Simultaneous lose/next, then reset mid-pause.
    cycle(1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b1, 1'b1);
    idle(2);
    reset_now();
    idle(5);
    cycle(1'b1, 1'b1, 1'b1);
    idle(12);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      cycle(r < 2, (r >= 2 && r < 6) || r == 10, (r >= 6 && r < 10) || r == 10);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
